// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide data memory (async read, whole-word write).
// Sub-word stores are performed as read-modify-write; bad addresses/funct3 fault without access.
module load_store_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] MEM_TOP    = 32'h0001FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [DATA_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_fault,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_a,
  output logic [DATA_WIDTH-1:0] o_mem_wd,
  input  logic [DATA_WIDTH-1:0] i_mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      case (f3)
        3'b000, 3'b001, 3'b010: bad = 1'b0;
        default:                bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b011, 3'b110, 3'b111: bad = 1'b1;
        default:                bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] format_load(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] rd);
    logic [DATA_WIDTH-1:0] v;
    case (f3)
      3'b000:  v = {{(DATA_WIDTH-8){rd[7]}}, rd[7:0]};
      3'b001:  v = {{(DATA_WIDTH-16){rd[15]}}, rd[15:0]};
      3'b010:  v = rd;
      3'b100:  v = {{(DATA_WIDTH-8){1'b0}}, rd[7:0]};
      3'b101:  v = {{(DATA_WIDTH-16){1'b0}}, rd[15:0]};
      default: v = {DATA_WIDTH{1'b0}};
    endcase
    return v;
  endfunction

  state_t                r_state;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [15:0]           r_wdata;
  logic                  r_fault;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_a;
  logic [DATA_WIDTH-1:0] r_mem_wd;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_fault;

  logic [DATA_WIDTH:0]   w_addr_limit;
  logic                  w_fault;
  logic                  w_sw_ok;
  logic [DATA_WIDTH-1:0] w_merge;

  // Fault and SW decisions are made from the request itself so mem_we can be registered for ACCESS.
  assign w_addr_limit = {1'b0, MEM_TOP} - {{(DATA_WIDTH-1){1'b0}}, 2'b11};
  assign w_fault      = ({1'b0, i_req_addr} > w_addr_limit) | funct3_illegal(i_req_we, i_req_funct3);
  assign w_sw_ok      = i_req_we & (i_req_funct3 == 3'b010) & ~w_fault;
  assign w_merge      = r_funct3[0] ? {i_mem_rd[DATA_WIDTH-1:16], r_wdata[15:0]}
                                    : {i_mem_rd[DATA_WIDTH-1:8],  r_wdata[7:0]};

  // Request FSM; RESP also accepts so a new request can start in the response cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_wdata      <= 16'h0000;
      r_fault      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_a      <= {DATA_WIDTH{1'b0}};
      r_mem_wd     <= {DATA_WIDTH{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_rdata <= {DATA_WIDTH{1'b0}};
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          r_resp_valid <= 1'b0;
          if (i_req_valid) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_wdata  <= i_req_wdata[15:0];
            r_fault  <= w_fault;
            r_mem_a  <= i_req_addr;
            r_mem_we <= w_sw_ok;
            r_mem_wd <= w_sw_ok ? i_req_wdata : {DATA_WIDTH{1'b0}};
            r_state  <= S_ACCESS;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (!r_fault && r_we && (r_funct3 != 3'b010)) begin
            r_mem_we <= 1'b1;
            r_mem_wd <= w_merge;
            r_state  <= S_WRITE;
          end else begin
            r_mem_we     <= 1'b0;
            r_mem_wd     <= {DATA_WIDTH{1'b0}};
            r_mem_a      <= {DATA_WIDTH{1'b0}};
            r_resp_valid <= 1'b1;
            r_resp_fault <= r_fault;
            r_resp_rdata <= (r_fault || r_we) ? {DATA_WIDTH{1'b0}} : format_load(r_funct3, i_mem_rd);
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          r_mem_we     <= 1'b0;
          r_mem_wd     <= {DATA_WIDTH{1'b0}};
          r_mem_a      <= {DATA_WIDTH{1'b0}};
          r_resp_valid <= 1'b1;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= {DATA_WIDTH{1'b0}};
          r_state      <= S_RESP;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset masks everything immediately so an interrupted read-modify-write never commits.
  assign o_req_ready  = ((r_state == S_IDLE) || (r_state == S_RESP)) & ~i_rst;
  assign o_mem_we     = r_mem_we & ~i_rst;
  assign o_mem_a      = i_rst ? {DATA_WIDTH{1'b0}} : r_mem_a;
  assign o_mem_wd     = i_rst ? {DATA_WIDTH{1'b0}} : r_mem_wd;
  assign o_resp_valid = r_resp_valid & ~i_rst;
  assign o_resp_rdata = i_rst ? {DATA_WIDTH{1'b0}} : r_resp_rdata;
  assign o_resp_fault = r_resp_fault & ~i_rst;

endmodule
